prirv32_dmem_resp: RTL and testbench
====================================

PRIRV32_DMEM_RESP -- requirements
Module: prirv32_dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal data array; must be a power of two.
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal range 1..4: cycles from request acceptance to resp_valid_o.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid_i, input, 1 bit: a request is present.
REQ-007 SHALL have port req_ready_o, output, 1 bit: the block can accept a request.
REQ-008 SHALL have port req_addr_i, input, 32 bits: byte address (EXU load/store effective address).
REQ-009 SHALL have port req_we_i, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port req_size_i, input, 2 bits: 00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-011 SHALL have port req_wdata_i, input, 32 bits: store data, right-justified.
REQ-012 SHALL have port resp_valid_o, output, 1 bit: a response is present.
REQ-013 SHALL have port resp_ready_i, input, 1 bit: the consumer accepts the response.
REQ-014 SHALL have port resp_rdata_o, output, 32 bits: load data, right-justified and zero-filled above the access size (the EXU sign-extends).
REQ-015 SHALL have port resp_err_o, output, 1 bit: the access faulted; qualified by resp_valid_o.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-017 SHALL drive req_ready_o = 1 only in IDLE.
REQ-018 SHALL accept a request on a rising edge where req_valid_i && req_ready_o.
REQ-019 SHALL, on acceptance, capture address, size, we and wdata, and load a latency counter with READ_LATENCY-1.
REQ-020 SHALL transition IDLE->RESP on acceptance when READ_LATENCY == 1, otherwise IDLE->WAIT.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP when the counter reaches 0, so resp_valid_o rises exactly READ_LATENCY edges after acceptance.
REQ-022 SHALL, in RESP, hold resp_valid_o = 1 with resp_rdata_o and resp_err_o stable until resp_ready_i = 1.
REQ-023 SHALL go RESP->IDLE on the edge where resp_valid_o && resp_ready_i; a new request is accepted no earlier than the following edge.
REQ-024 SHALL, for a store, commit the byte lanes selected by size and addr[1:0] to array word addr[31:2] on the accept edge, and return resp_rdata_o = 0.
REQ-025 SHALL, for a load, read word addr[31:2] on the accept edge and shift the addressed lane down to bit 0: byte = addr[1:0]*8, half = addr[1]*16.
REQ-026 SHALL flag out of range when addr[31:2] >= DEPTH_WORDS: set resp_err_o = 1, suppress any write, return resp_rdata_o = 0.
REQ-027 SHALL treat req_size_i = 11 as an error, with the same handling as out of range.
REQ-028 SHALL, when a store is accepted, return the stored value on a load accepted on any later cycle (no read-after-write hazard).

Reset
REQ-029 SHALL, while rst_i = 1, force state to IDLE, req_ready_o = 0, resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0 and counter = 0.
REQ-030 SHALL drive req_ready_o = 1 on the first cycle after rst_i deasserts.
REQ-031 SHALL NOT reset array contents.
REQ-032 SHALL, on reset during WAIT or RESP, discard the pending response; a store already committed stays committed.

Configuration
REQ-033 SHALL support macro DMEM_MISALIGN_TRAP_EN. When defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL return resp_err_o = 1 with no write and rdata 0. When undefined, the offending low address bits SHALL be forced to 0 (access aligned down) and no error is raised.

Structure
REQ-034 SHALL place the size encodings (SIZE_B/SIZE_H/SIZE_W) and the FSM state typedef in shared package prirv32_pkg.
REQ-035 SHALL isolate the array in sub-module prirv32_dmem_ram: one synchronous read/write port, 4 byte-enables.

Verification
REQ-036 SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid_o 1 edge after acceptance with READ_LATENCY = 1.
REQ-037 SHALL cover: after REQ-036, SB addr 0x13 data 0x5A, then LW 0x10 -> 0x5AADBEEF; LBU 0x13 -> 0x0000005A; LHU 0x12 -> 0x00005AAD.
REQ-038 SHALL cover: READ_LATENCY = 3 with resp_ready_i held 0 for 5 cycles -> resp_valid_o rises 3 edges after acceptance, data stable throughout, req_ready_o 0 until the handshake completes.
REQ-039 SHALL cover: LW addr 0x00001000 with DEPTH_WORDS = 1024 -> err 1, rdata 0; a subsequent SW to the same address leaves no array word modified.
REQ-040 SHALL cover: LW addr 0x12 -> err 1 with DMEM_MISALIGN_TRAP_EN defined; without it, returns the word at 0x10.
REQ-041 SHALL cover: rst_i asserted in WAIT -> resp_valid_o never rises; after release, req_ready_o = 1 and prior store data is still readable.

Source files
------------

// File: rtl/prirv32_pkg.sv
// prirv32_pkg -- definitions shared by the data-memory response block.
//   SIZE_B / SIZE_H / SIZE_W : req_size encodings (2'b11 is illegal)
//   dmem_state_e             : IDLE / WAIT / RESP handshake states
//   lane_mask()              : byte-enable pattern for a size at a byte offset
package prirv32_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  // Offset is expected to be already aligned for the access size.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SIZE_B:  m = 4'b0001 << off;
      SIZE_H:  m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/prirv32_dmem_ram.sv
// prirv32_dmem_ram -- single-port synchronous data array, 4 byte lanes.
//   clk   : clock
//   en    : port enable (read when we=0, write when we=1)
//   we    : write enable
//   be    : per-lane byte enables for writes
//   addr  : word index
//   wdata : lane-positioned write data
//   rdata : registered read data; holds its value until the next enabled read
// Contents are never reset.
module prirv32_dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One byte-wide array per lane keeps each lane a plain inferable memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) lane_mem[addr] <= wdata[gi*8 +: 8];
        end else begin
          lane_q <= lane_mem[addr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/prirv32_dmem_resp.sv
// prirv32_dmem_resp -- data memory with valid/ready request and response.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_valid_i/ready_o   : request handshake (ready only in IDLE)
//   req_addr_i            : byte address
//   req_we_i              : 1 = store, 0 = load
//   req_size_i            : 00 byte, 01 half, 10 word, 11 illegal
//   req_wdata_i           : right-justified store data
//   resp_valid_o/ready_i  : response handshake, held until accepted
//   resp_rdata_o          : right-justified, zero-filled load data (0 for stores/errors)
//   resp_err_o            : out-of-range, illegal size or (optionally) misaligned
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise they are silently aligned down.
module prirv32_dmem_resp
  import prirv32_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  dmem_state_e state_reg;
  logic [1:0]  cnt_reg;
  logic        err_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic [1:0]  off_reg;

  logic        accept;
  logic        in_range;
  logic        misalign;
  logic        req_err;
  logic [1:0]  eff_off;
  logic [31:0] ram_rdata;
  logic [31:0] rdata_shift;
  logic [31:0] lane_data;

  assign accept   = req_valid_i && req_ready_o;
  assign in_range = (req_addr_i[31:AW+2] == '0);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((req_size_i == SIZE_H) && req_addr_i[0]) ||
                    ((req_size_i == SIZE_W) && (req_addr_i[1:0] != 2'b00));
  assign eff_off  = req_addr_i[1:0];
`else
  assign misalign = 1'b0;
  always_comb begin
    case (req_size_i)
      SIZE_H:  eff_off = {req_addr_i[1], 1'b0};
      SIZE_W:  eff_off = 2'b00;
      default: eff_off = req_addr_i[1:0];
    endcase
  end
`endif

  assign req_err = !in_range || (req_size_i == 2'b11) || misalign;

  // The array is touched only on the accept edge and only for a clean access,
  // so its read register stays stable for the whole response.
  prirv32_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk_i),
    .en   (accept && !req_err),
    .we   (req_we_i),
    .be   (lane_mask(req_size_i, eff_off)),
    .addr (req_addr_i[AW+1:2]),
    .wdata(req_wdata_i << {eff_off, 3'b000}),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      size_reg  <= SIZE_B;
      off_reg   <= 2'b00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            err_reg   <= req_err;
            we_reg    <= req_we_i;
            size_reg  <= req_size_i;
            off_reg   <= eff_off;
            cnt_reg   <= LAT_M1;
            state_reg <= (READ_LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          // Leaving on the decrement that reaches zero puts resp_valid_o
          // exactly READ_LATENCY edges after acceptance.
          if (cnt_reg <= 2'd1) begin
            cnt_reg   <= 2'd0;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready_i) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rdata_shift = ram_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (size_reg)
      SIZE_B:  lane_data = {24'd0, rdata_shift[7:0]};
      SIZE_H:  lane_data = {16'd0, rdata_shift[15:0]};
      default: lane_data = rdata_shift;
    endcase
  end

  assign req_ready_o  = (state_reg == IDLE) && !rst_i;
  assign resp_valid_o = (state_reg == RESP);
  assign resp_err_o   = resp_valid_o && err_reg;
  assign resp_rdata_o = (resp_valid_o && !we_reg && !err_reg) ? lane_data : 32'd0;

endmodule

// File: tb/tb_prirv32_dmem_resp.sv
// tb_prirv32_dmem_resp -- directed bench for prirv32_dmem_resp.
// Two instances: READ_LATENCY=1 (dut0) and READ_LATENCY=3 (dut1), both 1024 words.
// A byte-level memory model predicts each response; a negedge monitor checks
// handshake and data every cycle, and literal expectations pin the model.
module tb_prirv32_dmem_resp;
  import prirv32_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        req_we     [2];
  logic [1:0]  req_size   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  prirv32_dmem_resp #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT_A)) u_dut0 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_we_i(req_we[0]), .req_size_i(req_size[0]),
    .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0])
  );

  prirv32_dmem_resp #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT_B)) u_dut1 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_we_i(req_we[1]), .req_size_i(req_size[1]),
    .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1])
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m  [2][DEPTH];
  bit          pend   [2];
  int          age    [2];
  logic [31:0] exp_rd [2];
  logic        exp_er [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Byte-level memory model: decides the fault, then moves bytes one at a time.
  task automatic model(input int d, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er);
    int off, nb, idx;
    logic [31:0] w;
    rd  = 32'd0;
    er  = 1'b0;
    off = int'(addr[1:0]);
    nb  = (size == SIZE_B) ? 1 : (size == SIZE_H) ? 2 : 4;
    if (size == 2'b11) er = 1'b1;
    if (addr >= 32'(DEPTH * 4)) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((off % nb) != 0) er = 1'b1;
`else
    off = off - (off % nb);
`endif
    if (!er) begin
      idx = int'(addr >> 2);
      w   = mem_m[d][idx];
      for (int b = 0; b < nb; b++) begin
        if (we) w[(off+b)*8 +: 8] = wdata[b*8 +: 8];
        else    rd[b*8 +: 8]      = w[(off+b)*8 +: 8];
      end
      if (we) mem_m[d][idx] = w;
    end
  endtask

  // Per-cycle monitor for both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        check("rst_ready", 32'(req_ready[d]), 32'd0);
        check("rst_valid", 32'(resp_valid[d]), 32'd0);
        check("rst_rdata", resp_rdata[d], 32'd0);
        check("rst_err", 32'(resp_err[d]), 32'd0);
      end else if (pend[d]) begin
        age[d]++;
        check("busy_ready", 32'(req_ready[d]), 32'd0);
        check("resp_valid", 32'(resp_valid[d]), 32'(age[d] >= lat_of(d)));
        if (resp_valid[d]) begin
          check("resp_rdata", resp_rdata[d], exp_rd[d]);
          check("resp_err", 32'(resp_err[d]), 32'(exp_er[d]));
        end
      end else begin
        check("idle_ready", 32'(req_ready[d]), 32'd1);
        check("idle_valid", 32'(resp_valid[d]), 32'd0);
      end
    end
  end

  task automatic txn(input int d, input bit we, input logic [1:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                     output logic [31:0] rd, output logic er, output int lat_seen);
    int n;
    logic [31:0] mrd;
    logic mer;
    rd = 32'd0; er = 1'b0; lat_seen = 0;
    @(negedge clk);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_addr[d] = addr; req_wdata[d] = wdata;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[d]) begin
      check("accept_timeout", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    model(d, we, size, addr, wdata, mrd, mer);
    @(posedge clk);
    pend[d] = 1'b1; age[d] = 0; exp_rd[d] = mrd; exp_er[d] = mer;
    #1 req_valid[d] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[d] && n < 50);
    lat_seen = n;
    if (!resp_valid[d]) begin
      check("resp_timeout", 32'(resp_valid[d]), 32'd1);
      pend[d] = 1'b0;
      return;
    end
    rd = resp_rdata[d]; er = resp_err[d];
    repeat (stall) @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
    pend[d] = 1'b0;
    $display("txn dut%0d %s size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             d, we ? "ST" : "LD", size, addr, wdata, rd, er, lat_seen);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'd0; req_we[d] = 1'b0;
      req_size[d] = SIZE_W; req_wdata[d] = 32'd0; resp_ready[d] = 1'b0;
      pend[d] = 1'b0; age[d] = 0; exp_rd[d] = 32'd0; exp_er[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst[0] = 1'b0; rst[1] = 1'b0;

    // Basic word store/load, latency 1
    txn(0, 1, SIZE_W, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
    check("sw_rdata", rd, 32'd0);
    check("sw_err", 32'(er), 32'd0);
    txn(0, 0, SIZE_W, 32'h10, 32'd0, 0, rd, er, lat);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 32'd0);
    check("lw_lat1", 32'(lat), 32'd1);

    // Byte store then word / byte / half loads
    txn(0, 1, SIZE_B, 32'h13, 32'h0000005A, 0, rd, er, lat);
    txn(0, 0, SIZE_W, 32'h10, 32'd0, 0, rd, er, lat);
    check("lw_after_sb", rd, 32'h5AADBEEF);
    txn(0, 0, SIZE_B, 32'h13, 32'd0, 0, rd, er, lat);
    check("lbu_13", rd, 32'h0000005A);
    txn(0, 0, SIZE_H, 32'h12, 32'd0, 0, rd, er, lat);
    check("lhu_12", rd, 32'h00005AAD);

    // Out of range: load faults, store must not alias onto word 0
    txn(0, 1, SIZE_W, 32'h0, 32'h11223344, 0, rd, er, lat);
    txn(0, 0, SIZE_W, 32'h00001000, 32'd0, 0, rd, er, lat);
    check("oor_lw_err", 32'(er), 32'd1);
    check("oor_lw_rdata", rd, 32'd0);
    txn(0, 1, SIZE_W, 32'h00001000, 32'hCAFEF00D, 0, rd, er, lat);
    check("oor_sw_err", 32'(er), 32'd1);
    txn(0, 0, SIZE_W, 32'h0, 32'd0, 0, rd, er, lat);
    check("word0_kept", rd, 32'h11223344);
    txn(0, 0, SIZE_W, 32'h10, 32'd0, 0, rd, er, lat);
    check("word10_kept", rd, 32'h5AADBEEF);

    // Illegal size
    txn(0, 0, 2'b11, 32'h10, 32'd0, 0, rd, er, lat);
    check("size11_err", 32'(er), 32'd1);
    check("size11_rdata", rd, 32'd0);

    // Misaligned word load
    txn(0, 0, SIZE_W, 32'h12, 32'd0, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("mis_lw_err", 32'(er), 32'd1);
    check("mis_lw_rdata", rd, 32'd0);
`else
    check("mis_lw_err", 32'(er), 32'd0);
    check("mis_lw_rdata", rd, 32'h5AADBEEF);
`endif

    // Half store into upper half of word 0
    txn(0, 1, SIZE_H, 32'h2, 32'h1234ABCD, 0, rd, er, lat);
    txn(0, 0, SIZE_W, 32'h0, 32'd0, 0, rd, er, lat);
    check("sh_word", rd, 32'hABCD3344);
    txn(0, 0, SIZE_B, 32'h1, 32'd0, 0, rd, er, lat);
    check("lbu_1", rd, 32'h00000033);

    // Latency 3 with a stalled consumer
    txn(1, 1, SIZE_W, 32'h20, 32'h01020304, 0, rd, er, lat);
    check("lat3_sw_lat", 32'(lat), 32'd3);
    txn(1, 0, SIZE_W, 32'h20, 32'd0, 5, rd, er, lat);
    check("lat3_lw_lat", 32'(lat), 32'd3);
    check("lat3_lw_rdata", rd, 32'h01020304);

    // Reset while in WAIT drops the pending response
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_size[1] = SIZE_W; req_addr[1] = 32'h20;
    check("rst_test_ready", 32'(req_ready[1]), 32'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0; rst[1] = 1'b1;
    $display("txn dut1 LD addr=00000020 reset asserted in WAIT");
    repeat (2) @(posedge clk);
    #1 rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_ready", 32'(req_ready[1]), 32'd1);
    txn(1, 0, SIZE_W, 32'h20, 32'd0, 0, rd, er, lat);
    check("post_rst_data", rd, 32'h01020304);
    check("post_rst_err", 32'(er), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
